sincos_decimator: RTL and testbench
===================================

SINCOS_DECIMATOR -- requirements
Module: sincos_decimator

Interface
REQ-001 The block SHALL have parameter DECIM, default 4, giving the decimation ratio; it SHALL be a power of two, from 2 to 64.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving the width of each sin and cos sample.
REQ-003 Port aclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port s_axis_dout_tvalid, input, 1 bit: an input beat is valid, driven by the CORDIC m_axis_dout_tvalid.
REQ-006 Port s_axis_dout_tdata, input, 2*DATA_W bits: {sin, cos}, sin in the upper half, both signed Q1.14.
REQ-007 Port s_axis_dout_tready, output, 1 bit: the block accepts an input beat.
REQ-008 Port m_axis_tvalid, output, 1 bit: an output beat is valid.
REQ-009 Port m_axis_tdata, output, 2*DATA_W bits: {sin_avg, cos_avg}, same format as the input.
REQ-010 Port m_axis_tready, input, 1 bit: the downstream block (FIR side) accepts the output beat.

Function
REQ-011 An input beat SHALL be accepted only on a cycle where s_axis_dout_tvalid and s_axis_dout_tready are both 1; no other cycle SHALL change the accumulators or the beat counter.
REQ-012 Two accumulators of DATA_W+log2(DECIM) bits SHALL sign-extend and add sin and cos on each accepted beat.
REQ-013 The beat counter SHALL run 0..DECIM-1 and wrap to 0 on the accepted beat where it reads DECIM-1 (the dump beat).
REQ-014 On the dump beat, the block SHALL:
- push {(acc_sin+sin)>>>log2(DECIM), (acc_cos+cos)>>>log2(DECIM)} into the output buffer (arithmetic shift, round toward minus infinity, low DATA_W bits);
- load both accumulators with 0, not with the current sample.
REQ-015 The output buffer SHALL be a 2-entry FIFO; m_axis_tvalid SHALL be 1 whenever it is not empty, and m_axis_tdata SHALL show the head entry.
REQ-016 m_axis_tdata SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 The head entry SHALL be popped on m_axis_tvalid && m_axis_tready.
REQ-018 s_axis_dout_tready SHALL be the registered value of "FIFO not full", so it never depends combinationally on m_axis_tready.
REQ-019 When the FIFO is full, s_axis_dout_tready SHALL be 0 on every cycle, even for beats that are not dump beats.
REQ-020 On a cycle with both a push and a pop, the FIFO occupancy SHALL stay the same and data order SHALL be preserved.
REQ-021 Latency: m_axis_tvalid SHALL rise on the cycle after the dump beat is accepted, when the FIFO was empty.
REQ-022 Gaps in s_axis_dout_tvalid SHALL NOT advance the counter or change the accumulators.

Reset
REQ-023 While areset=1, the block SHALL immediately and asynchronously clear:
- both accumulators, the beat counter and the FIFO pointers/occupancy;
- m_axis_tvalid=0, m_axis_tdata=0, s_axis_dout_tready=0.
REQ-024 On the first rising edge of aclk after areset falls, s_axis_dout_tready SHALL go to 1.
REQ-025 A reset in the middle of a decimation window SHALL discard the partial sum and any buffered outputs; no stale beat SHALL appear after reset.

Structure
REQ-026 DECIM_LOG2, the accumulator width function and the Q1.14 constants SHALL live in the shared dsp package.
REQ-027 The 2-entry FIFO SHALL be one sub-module, axis_fifo2, parameterised on data width.

Verification
REQ-028 DECIM=4, constant input {1000, -1000}, m_axis_tready=1 -> one output per 4 accepted beats equal to {1000, -1000}, with tvalid high on the cycle after each 4th beat.
REQ-029 sin = 1,2,3,4 and cos = -1,-2,-3,-4 -> output {2, -3} (10>>>2 = 2; -10>>>2 = -3).
REQ-030 m_axis_tready=0, 12 input beats offered -> outputs 1 and 2 buffered; s_axis_dout_tready=0 from the cycle after beat 8; after m_axis_tready=1, beats 9-12 complete output 3.
REQ-031 Random s_axis_dout_tvalid gaps with an input ramp of +4 per accepted beat -> output sequence matches the model with no missing or extra beats.
REQ-032 areset pulse after 2 beats of a window with 1 output buffered -> m_axis_tvalid=0 at once; the next output needs 4 fresh beats and equals their average.
REQ-033 Full-scale input {0x7FFF, 0x8000} for 4 beats -> output {0x7FFF, 0x8000} with no overflow.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP definitions: decimation helpers, Q1.14 constants and the
// occupancy states of the small output FIFO.
package dsp_pkg;

   localparam int unsigned Q14_FRAC_W = 14;
   localparam logic signed [15:0] Q14_ONE = 16'sh4000;
   localparam logic signed [15:0] Q14_MAX = 16'sh7FFF;
   localparam logic signed [15:0] Q14_MIN = 16'sh8000;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   function automatic int unsigned decim_log2(input int unsigned decim);
      return $clog2(decim);
   endfunction

   // Accumulator must hold DECIM full-scale samples without overflow.
   function automatic int unsigned acc_width(input int unsigned data_w,
                                             input int unsigned decim);
      return data_w + decim_log2(decim);
   endfunction

endpackage

// File: rtl/axis_fifo2.sv
// Two-entry AXI-stream FIFO with registered head data, valid and ready.
module axis_fifo2
   import dsp_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready
);

   fifo_state_e       state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
   logic              push, pop;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      push    = in_valid && in_ready;
      pop     = out_valid && out_ready;
      case (state_q)
         FIFO_EMPTY: begin
            if (push) begin
               head_d  = in_data;
               state_d = FIFO_ONE;
            end
         end
         FIFO_ONE: begin
            if (push && pop) begin
               head_d = in_data;
            end else if (push) begin
               tail_d  = in_data;
               state_d = FIFO_FULL;
            end else if (pop) begin
               state_d = FIFO_EMPTY;
            end
         end
         default: begin
            if (pop) begin
               head_d = tail_q;
               if (push) tail_d = in_data;
               else      state_d = FIFO_ONE;
            end
         end
      endcase
   end

   // Valid/ready are registered from next occupancy so they track the state exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FIFO_EMPTY;
         head_q    <= '0;
         tail_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         out_valid <= (state_d != FIFO_EMPTY);
         in_ready  <= (state_d != FIFO_FULL);
      end
   end

   assign out_data = head_q;

endmodule

// File: rtl/sincos_decimator.sv
// Boxcar-averaging decimator for CORDIC {sin, cos} samples; one averaged
// beat per DECIM accepted input beats, buffered in a 2-entry FIFO.
module sincos_decimator
   import dsp_pkg::*;
#(
   parameter int unsigned DECIM  = 4,
   parameter int unsigned DATA_W = 16
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic                s_axis_dout_tvalid,
   input  logic [2*DATA_W-1:0] s_axis_dout_tdata,
   output logic                s_axis_dout_tready,
   output logic                m_axis_tvalid,
   output logic [2*DATA_W-1:0] m_axis_tdata,
   input  logic                m_axis_tready
);

   localparam int unsigned LOG2  = decim_log2(DECIM);
   localparam int unsigned ACC_W = acc_width(DATA_W, DECIM);
   localparam int unsigned DW2   = 2 * DATA_W;

   logic signed [DATA_W-1:0] in_sin, in_cos;
   logic signed [ACC_W-1:0]  acc_sin, acc_cos, sum_sin, sum_cos;
   logic [LOG2-1:0]          beat_cnt;
   logic                     accept, dump;
   logic [DW2-1:0]           push_data;

   assign in_sin = s_axis_dout_tdata[DW2-1:DATA_W];
   assign in_cos = s_axis_dout_tdata[DATA_W-1:0];

   always_comb begin
      accept    = s_axis_dout_tvalid && s_axis_dout_tready;
      dump      = accept && (beat_cnt == LOG2'(DECIM - 1));
      sum_sin   = acc_sin + ACC_W'(in_sin);
      sum_cos   = acc_cos + ACC_W'(in_cos);
      push_data = {DATA_W'(sum_sin >>> LOG2), DATA_W'(sum_cos >>> LOG2)};
   end

   // Dump beat restarts the window from zero rather than from the current sample.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         acc_sin  <= '0;
         acc_cos  <= '0;
         beat_cnt <= '0;
      end else if (accept) begin
         if (dump) begin
            acc_sin  <= '0;
            acc_cos  <= '0;
            beat_cnt <= '0;
         end else begin
            acc_sin  <= sum_sin;
            acc_cos  <= sum_cos;
            beat_cnt <= beat_cnt + LOG2'(1);
         end
      end
   end

   axis_fifo2 #(
      .DATA_W (DW2)
   ) u_fifo (
      .clk       (aclk),
      .rst       (areset),
      .in_valid  (dump),
      .in_data   (push_data),
      .in_ready  (s_axis_dout_tready),
      .out_valid (m_axis_tvalid),
      .out_data  (m_axis_tdata),
      .out_ready (m_axis_tready)
   );

endmodule

// File: tb/tb_sincos_decimator.sv
// Scoreboard bench for sincos_decimator (DECIM=4, DATA_W=16).
module tb_sincos_decimator;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready = 1'b0;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_out = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_out = '0;
   int          mdl_sin = 0, mdl_cos = 0, mdl_cnt = 0;

   sincos_decimator #(.DECIM(4), .DATA_W(16)) dut (
      .aclk               (aclk),
      .areset             (areset),
      .s_axis_dout_tvalid (s_valid),
      .s_axis_dout_tdata  (s_data),
      .s_axis_dout_tready (s_ready),
      .m_axis_tvalid      (m_valid),
      .m_axis_tdata       (m_data),
      .m_axis_tready      (m_ready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_accept(input logic [31:0] d);
      int s, c;
      s = $signed(d[31:16]);
      c = $signed(d[15:0]);
      mdl_sin += s;
      mdl_cos += c;
      mdl_cnt++;
      if (mdl_cnt == 4) begin
         exp_q.push_back({16'(mdl_sin >>> 2), 16'(mdl_cos >>> 2)});
         mdl_sin = 0;
         mdl_cos = 0;
         mdl_cnt = 0;
      end
   endtask

   // Inputs change at negedge; handshakes are evaluated 1 unit later and commit at the next posedge.
   task automatic cycle(output bit acc);
      #1;
      acc = s_valid && s_ready;
      if (m_valid && m_ready) begin
         n_out++;
         last_out = m_data;
         if (exp_q.size() == 0) check("unexpected_out", 32'(m_valid), 32'd0);
         else                   check("out_data", m_data, exp_q.pop_front());
      end
      if (acc) model_accept(s_data);
      @(posedge aclk);
      @(negedge aclk);
   endtask

   task automatic send(input int sin, input int cos);
      bit acc = 1'b0;
      s_valid = 1'b1;
      s_data  = {16'(sin), 16'(cos)};
      for (int i = 0; i < 100 && !acc; i++) cycle(acc);
      if (!acc) check("send_timeout", 32'(acc), 32'd1);
      s_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      m_ready = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(acc);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_valid", 32'(m_valid), 32'd0);
   endtask

   task automatic do_reset();
      areset = 1'b1;
      #1;
      check("rst_valid", 32'(m_valid), 32'd0);
      check("rst_data", m_data, 32'd0);
      check("rst_ready", 32'(s_ready), 32'd0);
      exp_q.delete();
      mdl_sin = 0;
      mdl_cos = 0;
      mdl_cnt = 0;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      #1;
      check("ready_at_release", 32'(s_ready), 32'd0);
      @(posedge aclk);
      #1;
      check("ready_after_reset", 32'(s_ready), 32'd1);
      @(negedge aclk);
   endtask

   initial begin
      bit acc;
      int ramp, n_acc, out0;

      #2;
      do_reset();

      // Constant input, downstream always ready, latency after the dump beat.
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(1000, -1000);
         if (k == 2) check("pre_dump_valid", 32'(m_valid), 32'd0);
         if (k == 3 || k == 7) check("dump_latency", 32'(m_valid), 32'd1);
      end
      drain();
      check("const_value", last_out, {16'd1000, 16'hFC18});

      // Floor rounding of negative averages.
      for (int k = 1; k <= 4; k++) send(k, -k);
      drain();
      check("floor_value", last_out, {16'd2, 16'hFFFD});

      // Backpressure: two outputs buffered, input stalls until downstream drains.
      out0 = n_out;
      m_ready = 1'b0;
      for (int k = 1; k <= 8; k++) send(100 * k, -7 * k);
      #1;
      check("full_ready_low", 32'(s_ready), 32'd0);
      check("full_valid", 32'(m_valid), 32'd1);
      s_valid = 1'b1;
      s_data  = {16'(900), 16'(-63)};
      for (int i = 0; i < 3; i++) begin
         cycle(acc);
         check("full_no_accept", 32'(acc), 32'd0);
         check("stall_data", m_data, exp_q[0]);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int k = 9; k <= 12; k++) send(100 * k, -7 * k);
      drain();
      check("bp_out_count", 32'(n_out - out0), 32'd3);

      // Random input gaps and downstream stalls with a +4 ramp.
      out0  = n_out;
      ramp  = -400;
      n_acc = 0;
      for (int i = 0; i < 200; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = {16'(ramp), 16'(-ramp)};
         m_ready = ($urandom_range(0, 3) != 0);
         cycle(acc);
         if (acc) begin
            ramp += 4;
            n_acc++;
         end
      end
      s_valid = 1'b0;
      while (n_acc % 4 != 0) begin
         send(ramp, -ramp);
         ramp += 4;
         n_acc++;
      end
      drain();
      check("rand_out_count", 32'(n_out - out0), 32'(n_acc / 4));

      // Reset mid-window with one output buffered.
      m_ready = 1'b0;
      for (int k = 0; k < 6; k++) send(3000 + k, -3000 - k);
      check("pre_reset_valid", 32'(m_valid), 32'd1);
      do_reset();
      check("post_reset_valid", 32'(m_valid), 32'd0);
      m_ready = 1'b1;
      for (int k = 0; k < 4; k++) send(40 + 10 * k, -40 - 10 * k);
      drain();
      check("post_reset_value", last_out, {16'd55, 16'hFFC9});

      // Full-scale input must not overflow.
      for (int k = 0; k < 4; k++) send(32767, -32768);
      drain();
      check("fullscale_value", last_out, {16'h7FFF, 16'h8000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
